exec_ctrl_seq: RTL and testbench

Parametrised execute-stage control unit for the 16-bit MIPS datapath. It sits between the decode stage and the ALU/multiply-divide unit and turns the 2-bit ALUOp and the R-type function field into a registered ALU control word and a registered jump-register flag. It adds multi-cycle MUL/DIV sequencing with a pipeline stall, a flush/abort path and an illegal-function flag.

---
 rtl/mips_ctrl_pkg.sv | 43 ++++
 rtl/alu_funct_decode.sv | 49 ++++
 rtl/exec_ctrl_seq.sv | 137 +++++++++++++
 tb/tb_exec_ctrl_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS execute-stage control path: ALUOp, ALU control,
// function codes, sequencer states and the decoder result payload.
package mips_ctrl_pkg;

   localparam int unsigned ALU_OP_W   = 2;
   localparam int unsigned ALU_CTRL_W = 3;
   localparam int unsigned FUNCT_B_W  = 4;

   localparam logic [ALU_OP_W-1:0] ALUOP_RTYPE = 2'b00;
   localparam logic [ALU_OP_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [ALU_OP_W-1:0] ALUOP_SLT   = 2'b10;
   localparam logic [ALU_OP_W-1:0] ALUOP_ADD   = 2'b11;

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b100;

   localparam logic [FUNCT_B_W-1:0] FUNCT_ADD = 4'b0000;
   localparam logic [FUNCT_B_W-1:0] FUNCT_SUB = 4'b0001;
   localparam logic [FUNCT_B_W-1:0] FUNCT_AND = 4'b0010;
   localparam logic [FUNCT_B_W-1:0] FUNCT_OR  = 4'b0011;
   localparam logic [FUNCT_B_W-1:0] FUNCT_SLT = 4'b0100;
   localparam logic [FUNCT_B_W-1:0] FUNCT_MUL = 4'b0101;
   localparam logic [FUNCT_B_W-1:0] FUNCT_DIV = 4'b0110;
   localparam logic [FUNCT_B_W-1:0] FUNCT_JR  = 4'b1000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MD_RUN  = 2'd1,
      MD_DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic [ALU_CTRL_W-1:0] alu_ctrl;
      logic                  jr;
      logic                  is_md;
      logic                  md_op;
      logic                  illegal;
   } dec_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational ALU control decoder: {alu_op, funct} -> ALU select, JR,
// multiply/divide request and illegal-function flag.
module alu_funct_decode
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned FUNCT_W = 4
) (
   input  logic [ALU_OP_W-1:0] alu_op,
   input  logic [FUNCT_W-1:0]  funct,
   output dec_t                dec_c
);

   logic                 hi_zero;
   logic [FUNCT_B_W-1:0] funct_lo;

   // Only the low four bits carry defined codes; anything above must be zero.
   assign hi_zero  = ((funct >> FUNCT_B_W) == '0);
   assign funct_lo = funct[FUNCT_B_W-1:0];

   always_comb begin
      dec_c = '0;
      case (alu_op)
         ALUOP_ADD: dec_c.alu_ctrl = ALU_ADD;
         ALUOP_SLT: dec_c.alu_ctrl = ALU_SLT;
         ALUOP_SUB: dec_c.alu_ctrl = ALU_SUB;
         default: begin
            if (!hi_zero) begin
               dec_c.illegal = 1'b1;
            end else begin
               case (funct_lo)
                  FUNCT_ADD: dec_c.alu_ctrl = ALU_ADD;
                  FUNCT_SUB: dec_c.alu_ctrl = ALU_SUB;
                  FUNCT_AND: dec_c.alu_ctrl = ALU_AND;
                  FUNCT_OR:  dec_c.alu_ctrl = ALU_OR;
                  FUNCT_SLT: dec_c.alu_ctrl = ALU_SLT;
                  FUNCT_JR:  dec_c.jr       = 1'b1;
                  FUNCT_MUL: dec_c.is_md    = 1'b1;
                  FUNCT_DIV: begin
                     dec_c.is_md = 1'b1;
                     dec_c.md_op = 1'b1;
                  end
                  default:   dec_c.illegal  = 1'b1;
               endcase
            end
         end
      endcase
   end

endmodule

// File: rtl/exec_ctrl_seq.sv
// Execute-stage control: registers the ALU decode, sequences multi-cycle
// MUL/DIV with a pipeline stall, and handles flush/abort.
module exec_ctrl_seq
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned FUNCT_W   = 4,
   parameter int unsigned MD_CYCLES = 16,
   parameter int unsigned CNT_W     = $clog2(MD_CYCLES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_in,
   output logic                  in_ready,
   input  logic [ALU_OP_W-1:0]   alu_op,
   input  logic [FUNCT_W-1:0]    funct,
   input  logic                  flush,
   output logic                  valid_out,
   output logic [ALU_CTRL_W-1:0] alu_ctrl,
   output logic                  jr_ctrl,
   output logic                  md_start,
   output logic                  md_op,
   output logic                  md_abort,
   output logic                  stall,
   output logic                  illegal
);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  valid_out_q, valid_out_d;
   logic [ALU_CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
   logic                  jr_hold_q, jr_hold_d;
   logic                  ill_hold_q, ill_hold_d;
   logic                  jr_ctrl_q, jr_ctrl_d;
   logic                  illegal_q, illegal_d;
   logic                  md_start_q, md_start_d;
   logic                  md_op_q, md_op_d;
   logic                  md_abort_q, md_abort_d;
   logic                  accept_c;
   dec_t                  dec_c;

   alu_funct_decode #(.FUNCT_W(FUNCT_W)) u_dec (
      .alu_op (alu_op),
      .funct  (funct),
      .dec_c  (dec_c)
   );

   // MD_DONE already frees the unit, so a new instruction can follow the result.
   assign in_ready = (state_q != MD_RUN);
   assign stall    = (state_q == MD_RUN);
   assign accept_c = valid_in && in_ready && !flush;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      valid_out_d = 1'b0;
      alu_ctrl_d  = alu_ctrl_q;
      jr_hold_d   = jr_hold_q;
      ill_hold_d  = ill_hold_q;
      md_op_d     = md_op_q;
      md_start_d  = 1'b0;
      md_abort_d  = 1'b0;
      jr_ctrl_d   = 1'b0;
      illegal_d   = 1'b0;

      case (state_q)
         MD_RUN: begin
            if (flush) begin
               state_d    = IDLE;
               cnt_d      = '0;
               md_abort_d = 1'b1;
            end else if (cnt_q == '0) begin
               state_d     = MD_DONE;
               valid_out_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            if (accept_c) begin
               alu_ctrl_d = dec_c.alu_ctrl;
               jr_hold_d  = dec_c.jr;
               ill_hold_d = dec_c.illegal;
               md_op_d    = dec_c.md_op;
               if (dec_c.is_md) begin
                  state_d    = MD_RUN;
                  cnt_d      = CNT_W'(MD_CYCLES - 1);
                  md_start_d = 1'b1;
               end else begin
                  valid_out_d = 1'b1;
               end
            end
         end
      endcase

      // Held flags are only visible alongside a valid result.
      jr_ctrl_d = valid_out_d && jr_hold_d;
      illegal_d = valid_out_d && ill_hold_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         valid_out_q <= 1'b0;
         alu_ctrl_q  <= '0;
         jr_hold_q   <= 1'b0;
         ill_hold_q  <= 1'b0;
         jr_ctrl_q   <= 1'b0;
         illegal_q   <= 1'b0;
         md_start_q  <= 1'b0;
         md_op_q     <= 1'b0;
         md_abort_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         valid_out_q <= valid_out_d;
         alu_ctrl_q  <= alu_ctrl_d;
         jr_hold_q   <= jr_hold_d;
         ill_hold_q  <= ill_hold_d;
         jr_ctrl_q   <= jr_ctrl_d;
         illegal_q   <= illegal_d;
         md_start_q  <= md_start_d;
         md_op_q     <= md_op_d;
         md_abort_q  <= md_abort_d;
      end
   end

   assign valid_out = valid_out_q;
   assign alu_ctrl  = alu_ctrl_q;
   assign jr_ctrl   = jr_ctrl_q;
   assign illegal   = illegal_q;
   assign md_start  = md_start_q;
   assign md_op     = md_op_q;
   assign md_abort  = md_abort_q;

endmodule

// File: tb/tb_exec_ctrl_seq.sv
// Bench for exec_ctrl_seq: directed scenarios then random traffic, all checked
// against a cycle-indexed reference model of the execute control behaviour.
module tb_exec_ctrl_seq;

   localparam int unsigned FW = 4;
   localparam int unsigned MD = 16;

   logic          clk;
   logic          rst_n;
   logic          valid_in;
   logic          in_ready;
   logic [1:0]    alu_op;
   logic [FW-1:0] funct;
   logic          flush;
   logic          valid_out;
   logic [2:0]    alu_ctrl;
   logic          jr_ctrl;
   logic          md_start;
   logic          md_op;
   logic          md_abort;
   logic          stall;
   logic          illegal;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model state
   int         cyc;
   bit         md_live;
   int         md_acc;
   logic       e_valid;
   logic [2:0] e_alu;
   logic       e_jr_h;
   logic       e_ill_h;
   logic       e_mdop;
   logic       e_start;
   logic       e_abort;

   exec_ctrl_seq #(.FUNCT_W(FW), .MD_CYCLES(MD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (valid_in),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .funct     (funct),
      .flush     (flush),
      .valid_out (valid_out),
      .alu_ctrl  (alu_ctrl),
      .jr_ctrl   (jr_ctrl),
      .md_start  (md_start),
      .md_op     (md_op),
      .md_abort  (md_abort),
      .stall     (stall),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
      end
   endtask

   // Decode table written straight from the instruction definitions.
   task automatic ref_decode(input int op, input int f, output logic [2:0] a,
                             output logic j, output logic md, output logic mo,
                             output logic il);
      a = 3'd0; j = 1'b0; md = 1'b0; mo = 1'b0; il = 1'b0;
      if (op == 3)      a = 3'd0;
      else if (op == 2) a = 3'd4;
      else if (op == 1) a = 3'd1;
      else if (f <= 4)  a = 3'(f);
      else if (f == 8)  j = 1'b1;
      else if (f == 5)  md = 1'b1;
      else if (f == 6)  begin md = 1'b1; mo = 1'b1; end
      else              il = 1'b1;
   endtask

   task automatic model_reset();
      md_live = 1'b0; md_acc = -1000;
      e_valid = 1'b0; e_alu = 3'd0; e_jr_h = 1'b0; e_ill_h = 1'b0;
      e_mdop = 1'b0; e_start = 1'b0; e_abort = 1'b0;
   endtask

   function automatic bit exp_stall();
      return md_live && (cyc >= md_acc + 1) && (cyc <= md_acc + int'(MD));
   endfunction

   // Advance the model by one cycle using the inputs currently applied.
   task automatic model_step();
      logic [2:0] a;
      logic j, md, mo, il;
      bit st;
      st = exp_stall();
      e_valid = 1'b0; e_start = 1'b0; e_abort = 1'b0;
      if (st) begin
         if (flush) begin
            e_abort = 1'b1; md_live = 1'b0;
         end else if (cyc == md_acc + int'(MD)) begin
            e_valid = 1'b1; md_live = 1'b0;
         end
      end else if (valid_in && !flush) begin
         ref_decode(int'(alu_op), int'(funct), a, j, md, mo, il);
         e_alu = a; e_jr_h = j; e_ill_h = il; e_mdop = mo;
         if (md) begin
            md_live = 1'b1; md_acc = cyc; e_start = 1'b1;
         end else begin
            e_valid = 1'b1;
         end
      end
   endtask

   task automatic check_outputs();
      bit st;
      st = exp_stall();
      chk("in_ready",  8'(in_ready),  8'(!st));
      chk("stall",     8'(stall),     8'(st));
      chk("valid_out", 8'(valid_out), 8'(e_valid));
      chk("alu_ctrl",  8'(alu_ctrl),  8'(e_alu));
      chk("jr_ctrl",   8'(jr_ctrl),   8'(e_jr_h & e_valid));
      chk("illegal",   8'(illegal),   8'(e_ill_h & e_valid));
      chk("md_op",     8'(md_op),     8'(e_mdop));
      chk("md_start",  8'(md_start),  8'(e_start));
      chk("md_abort",  8'(md_abort),  8'(e_abort));
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [FW-1:0] f,
                        input logic fl);
      valid_in = v; alu_op = op; funct = f; flush = fl;
      model_step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 2'd0, '0, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_valid"}, 8'(valid_out), 8'd0);
      chk({tag, "_alu"},   8'(alu_ctrl),  8'd0);
      chk({tag, "_jr"},    8'(jr_ctrl),   8'd0);
      chk({tag, "_start"}, 8'(md_start),  8'd0);
      chk({tag, "_mdop"},  8'(md_op),     8'd0);
      chk({tag, "_abort"}, 8'(md_abort),  8'd0);
      chk({tag, "_stall"}, 8'(stall),     8'd0);
      chk({tag, "_ill"},   8'(illegal),   8'd0);
   endtask

   initial begin
      logic       v, fl;
      logic [1:0] op;
      logic [3:0] f;
      rst_n = 1'b0; valid_in = 1'b0; alu_op = 2'd0; funct = '0; flush = 1'b0;
      cyc = 0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check_outputs();

      // Decode sweep back to back, then JR, illegal, and ALUOp override
      for (int i = 0; i <= 4; i++) drive(1'b1, 2'd0, FW'(i), 1'b0);
      drive(1'b1, 2'd0, 4'b1000, 1'b0);
      drive(1'b1, 2'd0, 4'b1111, 1'b0);
      drive(1'b1, 2'd2, 4'($urandom_range(0, 15)), 1'b0);
      drive(1'b1, 2'd1, 4'b1111, 1'b0);
      drive(1'b1, 2'd3, 4'b0101, 1'b0);
      idle(2);

      // MUL full run, then DIV with a new accept in the result cycle
      drive(1'b1, 2'd0, 4'b0101, 1'b0);
      idle(int'(MD) + 2);
      drive(1'b1, 2'd0, 4'b0110, 1'b0);
      idle(int'(MD));
      drive(1'b1, 2'd3, 4'b0000, 1'b0);
      idle(2);

      // Flush on the 3rd MD_RUN cycle
      drive(1'b1, 2'd0, 4'b0101, 1'b0);
      idle(2);
      drive(1'b1, 2'd0, 4'b0001, 1'b1);
      idle(3);

      // Flush and ADD together in IDLE
      drive(1'b1, 2'd3, 4'b0000, 1'b1);
      idle(2);

      // Asynchronous reset on the 5th MD_RUN cycle
      drive(1'b1, 2'd0, 4'b0101, 1'b0);
      idle(4);
      #2 rst_n = 1'b0;
      #1 check_all_zero("rst_async");
      chk("rst_in_ready", 8'(in_ready), 8'd1);
      @(negedge clk);
      check_all_zero("rst_hold");
      rst_n = 1'b1;
      model_reset();
      check_outputs();
      idle(2);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         v  = ($urandom_range(0, 9) < 7);
         op = 2'($urandom_range(0, 3));
         f  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(5, 6))
                                          : 4'($urandom_range(0, 15));
         fl = ($urandom_range(0, 24) == 0);
         drive(v, op, f, fl);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
